// File: rtl/n_bit_accumulator.sv
// Batch accumulator behind the N-bit ripple adder: sums a valid/ready stream of
// unsigned operands up to in_last, then presents sum, beat count and sticky carry.
module n_bit_accumulator #(
    parameter int N  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] COUNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Unsigned add with the carry kept in bit N, which the upstream adder drops.
    function automatic logic [N:0] add_with_carry(input logic [N-1:0] a, input logic [N-1:0] b);
        add_with_carry = {1'b0, a} + {1'b0, b};
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic [N-1:0]  acc_r;
    logic [N-1:0]  acc_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic          ovf_r;
    logic          ovf_s;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          accept_s;
    logic          result_s;
    logic [N:0]    sum_ext_s;

    // Handshake qualifiers, built only from registered ready/valid.
    always_comb begin
        accept_s  = in_valid && in_ready_r;
        result_s  = out_valid_r && out_ready;
        sum_ext_s = add_with_carry(acc_r, in_data);
    end

    // Next-state and datapath update for the ACC/HOLD machine.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        count_s = count_r;
        ovf_s   = ovf_r;
        case (state_r)
            ST_ACC: begin
                if (accept_s) begin
                    acc_s = sum_ext_s[N-1:0];
                    ovf_s = ovf_r | sum_ext_s[N];
                    if (count_r == COUNT_MAX) begin
                        count_s = count_r;
                    end else begin
                        count_s = count_r + COUNT_ONE;
                    end
                    if (in_last) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_ACC;
                    end
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (result_s) begin
                    acc_s   = {N{1'b0}};
                    count_s = {CW{1'b0}};
                    ovf_s   = 1'b0;
                    state_s = ST_ACC;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                acc_s   = {N{1'b0}};
                count_s = {CW{1'b0}};
                ovf_s   = 1'b0;
                state_s = ST_ACC;
            end
        endcase
    end

    // State, datapath and registered handshake flags; ready/valid follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_ACC;
            acc_r       <= {N{1'b0}};
            count_r     <= {CW{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            count_r     <= count_s;
            ovf_r       <= ovf_s;
            in_ready_r  <= (state_s == ST_ACC);
            out_valid_r <= (state_s == ST_HOLD);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = acc_r;
    assign out_count = count_r;
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_n_bit_accumulator.sv
// Directed bench for n_bit_accumulator: vector table for batches plus hand-written
// sequences for backpressure, mid-batch reset and count saturation (CW=2 instance).
module tb_n_bit_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [7:0]  out_count;
    logic        out_ovf;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_in_data;
    logic        s_in_last;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_out_sum;
    logic [1:0]  s_out_count;
    logic        s_out_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    n_bit_accumulator #(.N(32), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    n_bit_accumulator #(.N(32), .CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_count(s_out_count), .out_ovf(s_out_ovf)
    );

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        last;
        logic        ordy;
        logic        e_in_ready;
        logic        e_out_valid;
        logic [31:0] e_sum;
        logic [7:0]  e_count;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic e_ir, input logic e_ov,
                            input logic [31:0] e_sum, input logic [7:0] e_cnt, input logic e_ovf);
        chk({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, e_ir});
        chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, e_ov});
        chk({tag, ".out_sum"}, {32'd0, out_sum}, {32'd0, e_sum});
        chk({tag, ".out_count"}, {56'd0, out_count}, {56'd0, e_cnt});
        chk({tag, ".out_ovf"}, {63'd0, out_ovf}, {63'd0, e_ovf});
    endtask

    initial begin
        // vld, data, last, out_ready -> in_ready, out_valid, sum, count, ovf after the edge
        vecs[0]  = '{1'b1, 32'd10,         1'b0, 1'b0, 1'b1, 1'b0, 32'd60 - 32'd50, 8'd1, 1'b0};
        vecs[1]  = '{1'b1, 32'd20,         1'b0, 1'b0, 1'b1, 1'b0, 32'd30,         8'd2, 1'b0};
        vecs[2]  = '{1'b1, 32'd30,         1'b1, 1'b0, 1'b0, 1'b1, 32'd60,         8'd3, 1'b0};
        vecs[3]  = '{1'b1, 32'd99,         1'b0, 1'b1, 1'b1, 1'b0, 32'd0,          8'd0, 1'b0};
        vecs[4]  = '{1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF,  8'd1, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0002,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0001,  8'd2, 1'b1};
        vecs[6]  = '{1'b0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b0, 32'd0,          8'd0, 1'b0};
        vecs[7]  = '{1'b1, 32'd5,          1'b1, 1'b1, 1'b0, 1'b1, 32'd5,          8'd1, 1'b0};
        vecs[8]  = '{1'b0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b0, 32'd0,          8'd0, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_1234,  1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1234,  8'd1, 1'b0};
        vecs[10] = '{1'b0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b0, 32'd0,          8'd0, 1'b0};
        vecs[11] = '{1'b1, 32'd3,          1'b0, 1'b0, 1'b1, 1'b0, 32'd3,          8'd1, 1'b0};
        vecs[12] = '{1'b0, 32'd50,         1'b1, 1'b0, 1'b1, 1'b0, 32'd3,          8'd1, 1'b0};
        vecs[13] = '{1'b1, 32'd4,          1'b1, 1'b0, 1'b0, 1'b1, 32'd7,          8'd2, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = 32'd0; s_in_last = 1'b0; s_out_ready = 1'b0;

        step();
        step();
        chk_main("reset", 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_main("reset_release", 1'b1, 1'b0, 32'd0, 8'd0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            in_valid  = vecs[i].vld;
            in_data   = vecs[i].data;
            in_last   = vecs[i].last;
            out_ready = vecs[i].ordy;
            step();
            chk_main($sformatf("vec%0d", i), vecs[i].e_in_ready, vecs[i].e_out_valid,
                     vecs[i].e_sum, vecs[i].e_count, vecs[i].e_ovf);
        end

        // Backpressure: HOLD with result 7/2, upstream keeps offering 7.
        in_valid = 1'b1; in_data = 32'd7; in_last = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_main($sformatf("bp%0d", i), 1'b0, 1'b1, 32'd7, 8'd2, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk_main("bp_release", 1'b1, 1'b0, 32'd0, 8'd0, 1'b0);
        out_ready = 1'b0;

        // Reset mid-batch discards 100+200 without presenting it.
        in_valid = 1'b1; in_data = 32'd100; in_last = 1'b0;
        step();
        in_data = 32'd200;
        step();
        chk_main("mid_partial", 1'b1, 1'b0, 32'd300, 8'd2, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk_main("mid_reset", 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_main("mid_release", 1'b1, 1'b0, 32'd0, 8'd0, 1'b0);
        in_valid = 1'b1; in_data = 32'd7; in_last = 1'b1;
        step();
        chk_main("mid_after", 1'b0, 1'b1, 32'd7, 8'd1, 1'b0);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Saturating count on the CW=2 instance: five beats of 1.
        s_in_valid = 1'b1; s_in_data = 32'd1;
        for (int i = 1; i <= 5; i++) begin
            s_in_last = (i == 5);
            step();
            chk($sformatf("sat%0d.count", i), {62'd0, s_out_count}, (i < 3) ? 64'(i) : 64'd3);
            chk($sformatf("sat%0d.sum", i), {32'd0, s_out_sum}, 64'(i));
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        chk("sat.out_valid", {63'd0, s_out_valid}, 64'd1);
        chk("sat.out_ovf", {63'd0, s_out_ovf}, 64'd0);
        chk("sat.in_ready", {63'd0, s_in_ready}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/n_bit_accumulator.md
# n_bit_accumulator

Sequential accumulation stage placed directly downstream of the team's N-bit ripple adder. It registers each adder result and feeds the running sum back as the next operand. It accepts a stream of N-bit unsigned operands over a valid/ready handshake and sums one batch, delimited by `in_last`. It then presents the batch sum, beat count and a sticky carry-out flag on an output handshake. Carry-out, which the combinational adder drops, is captured here as overflow.

## Interface
- `N`, default 32: operand and sum width in bits.
- `CW`, default 8: width of the beat counter.

- `clk`: input, 1 bit. Rising-edge clock.
- `rst_n`: input, 1 bit. Synchronous, active-low reset.
- `in_valid`: input, 1 bit. Upstream operand valid.
- `in_ready`: output, 1 bit. Block can accept an operand.
- `in_data`: input, N bits. Unsigned operand.
- `in_last`: input, 1 bit. Marks the final operand of a batch; qualified by the accept.
- `out_valid`: output, 1 bit. Batch result valid.
- `out_ready`: input, 1 bit. Downstream accepts the result.
- `out_sum`: output, N bits. Batch sum modulo 2^N.
- `out_count`: output, CW bits. Operands accepted in the batch, saturating.
- `out_ovf`: output, 1 bit. Set if any addition in the batch produced a carry-out.

## Operation
- Two states:
  - ACC: collecting operands.
  - HOLD: result presented.
- Accept condition: `in_valid && in_ready`.
- Result condition: `out_valid && out_ready`.
- `in_ready` is registered:
  - 1 in ACC.
  - 0 in HOLD and while `rst_n` = 0.
- `out_valid` is registered: 1 exactly while in HOLD.
- ACC, on an accept:
  - acc <= acc + `in_data`, as an N-bit sum.
  - ovf <= ovf | carry-out of that addition.
  - count <= count + 1, saturating at 2^CW-1; no wrap.
- ACC, accept with `in_last` = 1: the update above still applies, then the block goes to HOLD.
- ACC with no accept: acc, count and ovf hold their values.
- HOLD:
  - `in_ready` = 0; `in_valid`, `in_data` and `in_last` are ignored.
  - `out_sum`, `out_count` and `out_ovf` are stable.
- HOLD, on a result accept:
  - acc, count and ovf clear to 0.
  - The block returns to ACC, so `in_ready` = 1 the next cycle.
- The first beat of a batch always adds to 0, so carry cannot occur on beat 1.
- `out_sum`, `out_count` and `out_ovf` are driven directly from the acc, count and ovf registers.
  - They are visible at all times but meaningful only when `out_valid` = 1.
- Arithmetic is unsigned, with carry taken from bit N of an N+1-bit sum. No signed interpretation.
- A batch may have any length ≥ 1. An empty batch is impossible: `in_last` is only seen on an accepted beat.

## Timing
- Reset (`rst_n` = 0 sampled at a clock edge):
  - state = ACC.
  - acc = 0, count = 0, ovf = 0.
  - `out_valid` = 0, `in_ready` = 0.
  - `in_ready` rises on the first edge with `rst_n` = 1.
- Reset mid-batch or in HOLD: the partial sum and any pending result are discarded, with no output handshake.
- Throughput:
  - One operand per cycle in ACC.
  - Per batch, the block is unavailable to the input for at least 1 cycle (HOLD).
- Latency: `out_valid` = 1 in the cycle after the accept of the `in_last` beat; `out_sum` includes that beat.
- Minimum turnaround: if `out_ready` is held at 1, HOLD lasts exactly 1 cycle and `in_ready` returns 1 the following cycle.
- Backpressure: `out_valid` remains 1 and the outputs do not change until `out_ready` is sampled at 1.
- No combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`; both ready and valid are registered.
- Simultaneity: an input accept and an output accept cannot occur in the same cycle, because the states are mutually exclusive.

## Test plan
- Basic batch, N=32: accept 10, 20, 30 (last on the third) → next cycle `out_valid` = 1, `out_sum` = 60, `out_count` = 3, `out_ovf` = 0.
- Overflow, N=32: accept 0xFFFFFFFF then 0x00000002 (last) → `out_sum` = 0x00000001, `out_ovf` = 1. The following batch 5 (last) → `out_sum` = 5, `out_ovf` = 0.
- Single-beat batch: 0x1234 with `in_last` = 1 → `out_sum` = 0x1234, `out_count` = 1, HOLD for exactly 1 cycle with `out_ready` = 1.
- Backpressure: after a batch result, hold `out_ready` = 0 for 5 cycles while `in_valid` = 1 with data 7 → `in_ready` = 0 throughout, outputs unchanged, no operand absorbed. Raising `out_ready` → `in_ready` = 1 the next cycle.
- Count saturation, CW=2: five beats of 1 (last on the fifth) → `out_count` = 3, `out_sum` = 5, `out_ovf` = 0.
- Reset mid-batch: accept 100 and 200, assert `rst_n` = 0 for 1 cycle, then run batch 7 (last) → `out_sum` = 7, `out_count` = 1. `out_valid` is never 1 for the aborted batch.
